// File: rtl/bpm_update_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// bpm_update_scheduler_pkg
// Shared definitions for the BPM update scheduler:
//   - FSM state encoding (IDLE / CALC / LOAD / WAIT)
//   - signed step sizes contributed by each button pulse
//   - default BPM range and power-up value
//   - btn_sum(): net signed step requested by one cycle of button pulses
// ---------------------------------------------------------------------------
package bpm_update_scheduler_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Signed step contributed by each button
  localparam int DELTA_PLUS_1  = 1;
  localparam int DELTA_PLUS_5  = 5;
  localparam int DELTA_MINUS_1 = -1;
  localparam int DELTA_MINUS_5 = -5;

  // Default BPM range and value loaded after reset
  localparam int DEF_BPM_MIN     = 20;
  localparam int DEF_BPM_MAX     = 300;
  localparam int DEF_BPM_DEFAULT = 120;

  // Several buttons may pulse in the same cycle; their steps simply add up.
  function automatic int btn_sum(input logic plus_1, input logic plus_5,
                                 input logic minus_1, input logic minus_5);
    int total;
    total = 0;
    if (plus_1)  total += DELTA_PLUS_1;
    if (plus_5)  total += DELTA_PLUS_5;
    if (minus_1) total += DELTA_MINUS_1;
    if (minus_5) total += DELTA_MINUS_5;
    return total;
  endfunction

endpackage

// File: rtl/bpm_update_scheduler_clamp.sv
// ---------------------------------------------------------------------------
// bpm_clamp
// Combinational signed add followed by a clamp to [BPM_MIN, BPM_MAX].
// Ports:
//   base    in  W  signed base value (current BPM, or zero for absolute writes)
//   addend  in  W  signed addend (button delta, or absolute UART value)
//   result  out W  base + addend limited to [BPM_MIN, BPM_MAX]
//   sat     out 1  high when the raw sum lay outside the legal range
// ---------------------------------------------------------------------------
module bpm_clamp #(
  parameter int W       = 34,
  parameter int BPM_MIN = 20,
  parameter int BPM_MAX = 300
) (
  input  logic signed [W-1:0] base,
  input  logic signed [W-1:0] addend,
  output logic signed [W-1:0] result,
  output logic                sat
);

  localparam logic signed [W-1:0] LO = W'(BPM_MIN);
  localparam logic signed [W-1:0] HI = W'(BPM_MAX);

  logic signed [W-1:0] sum;

  // W carries two spare bits over the BPM width, so the raw sum of an
  // unsigned BPM and a small signed delta (or zero plus an unsigned UART
  // value) can never wrap before it is compared against the limits.
  always_comb begin
    sum    = base + addend;
    result = sum;
    sat    = 1'b0;
    if (sum < LO) begin
      result = LO;
      sat    = 1'b1;
    end else if (sum > HI) begin
      result = HI;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/bpm_update_scheduler.sv
// ---------------------------------------------------------------------------
// bpm_update_scheduler
// Collects BPM change requests from four button pulses and the UART command
// path, then sequences each accepted change into the BPM datapath: one
// clamped load per change, followed by a wait for the trigger-value recompute.
// Ports:
//   i_clk             in   1      clock
//   i_reset_n         in   1      synchronous active-low reset
//   i_btn_plus_1/5    in   1      single-cycle +1 / +5 requests
//   i_btn_minus_1/5   in   1      single-cycle -1 / -5 requests
//   i_uart_msg        in   1      single-cycle absolute BPM request
//   i_uart_bpm_count  in   BPM_W  absolute BPM, valid with i_uart_msg
//   i_calc_done       in   1      datapath finished recomputing
//   o_bpm_value       out  BPM_W  committed BPM
//   o_bpm_load        out  1      pulse: o_bpm_value just changed
//   o_bpm_changed     out  1      pulse: recompute finished
//   o_busy            out  1      FSM not in IDLE
//   o_sat             out  1      pulse: candidate was clamped
//   o_err             out  1      sticky recompute timeout
// ---------------------------------------------------------------------------
module bpm_update_scheduler
  import bpm_update_scheduler_pkg::*;
#(
  parameter int BPM_W       = 32,
  parameter int BPM_MIN     = DEF_BPM_MIN,
  parameter int BPM_MAX     = DEF_BPM_MAX,
  parameter int BPM_DEFAULT = DEF_BPM_DEFAULT,
  parameter int TIMEOUT     = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_plus_1,
  input  logic             i_btn_plus_5,
  input  logic             i_btn_minus_1,
  input  logic             i_btn_minus_5,
  input  logic             i_uart_msg,
  input  logic [BPM_W-1:0] i_uart_bpm_count,
  input  logic             i_calc_done,
  output logic [BPM_W-1:0] o_bpm_value,
  output logic             o_bpm_load,
  output logic             o_bpm_changed,
  output logic             o_busy,
  output logic             o_sat,
  output logic             o_err
);

  localparam int ACC_W = BPM_W + 2;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic signed [ACC_W-1:0] DELTA_LIM = ACC_W'(BPM_MAX - BPM_MIN);

  logic [1:0]              state;
  logic signed [ACC_W-1:0] delta_acc;
  logic                    uart_pend;
  logic [BPM_W-1:0]        uart_val;
  logic                    take_uart;
  logic signed [ACC_W-1:0] take_operand;
  logic [BPM_W-1:0]        cand_q;
  logic [TMR_W-1:0]        timer;

  logic                    take_btn;
  logic signed [ACC_W-1:0] step;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] clamp_base;
  logic signed [ACC_W-1:0] clamp_result;
  logic                    clamp_sat;

  assign o_busy = (state != ST_IDLE);

  // IDLE hands the button delta to CALC only when no UART value is waiting.
  assign take_btn = (state == ST_IDLE) && !uart_pend && (delta_acc != '0);

  // Next value of the button accumulator. When IDLE is taking the current
  // delta this cycle, this cycle's pulses start a fresh accumulation instead.
  // The accumulator saturates at the width of the legal BPM range, since any
  // larger step would clamp to the same end point anyway.
  always_comb begin
    step     = ACC_W'(btn_sum(i_btn_plus_1, i_btn_plus_5,
                              i_btn_minus_1, i_btn_minus_5));
    acc_sum  = (take_btn ? '0 : delta_acc) + step;
    acc_next = acc_sum;
    if (acc_sum > DELTA_LIM) begin
      acc_next = DELTA_LIM;
    end else if (acc_sum < -DELTA_LIM) begin
      acc_next = -DELTA_LIM;
    end
  end

  // Absolute UART writes start from zero; button deltas are relative to the
  // committed value.
  assign clamp_base = take_uart ? '0 : {2'b00, o_bpm_value};

  bpm_clamp #(
    .W       (ACC_W),
    .BPM_MIN (BPM_MIN),
    .BPM_MAX (BPM_MAX)
  ) u_clamp (
    .base   (clamp_base),
    .addend (take_operand),
    .result (clamp_result),
    .sat    (clamp_sat)
  );

  // Pending-request capture and the IDLE/CALC/LOAD/WAIT sequencer.
  // Reset drops into LOAD with the default as candidate, so the datapath
  // always sees an initial load. IDLE copies the chosen request into
  // take_operand, leaving the pending registers free to collect new pulses
  // while the change is in flight. A UART write overrides any button delta
  // collected so far, including pulses in its own cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= ST_LOAD;
      o_bpm_value   <= BPM_W'(BPM_DEFAULT);
      cand_q        <= BPM_W'(BPM_DEFAULT);
      delta_acc     <= '0;
      uart_pend     <= 1'b0;
      uart_val      <= '0;
      take_uart     <= 1'b0;
      take_operand  <= '0;
      timer         <= '0;
      o_bpm_load    <= 1'b0;
      o_bpm_changed <= 1'b0;
      o_sat         <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_bpm_load    <= 1'b0;
      o_bpm_changed <= 1'b0;
      o_sat         <= 1'b0;

      if (i_uart_msg) begin
        uart_pend <= 1'b1;
        uart_val  <= i_uart_bpm_count;
        delta_acc <= '0;
      end else begin
        if ((state == ST_IDLE) && uart_pend) begin
          uart_pend <= 1'b0;
        end
        delta_acc <= acc_next;
      end

      case (state)
        ST_IDLE: begin
          if (uart_pend) begin
            take_uart    <= 1'b1;
            take_operand <= {2'b00, uart_val};
            state        <= ST_CALC;
          end else if (take_btn) begin
            take_uart    <= 1'b0;
            take_operand <= delta_acc;
            state        <= ST_CALC;
          end
        end
        ST_CALC: begin
          o_sat  <= clamp_sat;
          cand_q <= clamp_result[BPM_W-1:0];
          state  <= (clamp_result == {2'b00, o_bpm_value}) ? ST_IDLE : ST_LOAD;
        end
        ST_LOAD: begin
          o_bpm_value <= cand_q;
          o_bpm_load  <= 1'b1;
          timer       <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_calc_done) begin
            o_bpm_changed <= 1'b1;
            state         <= ST_IDLE;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            o_err <= 1'b1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bpm_update_scheduler
// Directed bench for bpm_update_scheduler: reset/initial load, button steps,
// accumulation during WAIT, clamping at both ends, UART priority, ignored
// done pulses, recompute timeout and reset out of WAIT.
// ---------------------------------------------------------------------------
module tb_bpm_update_scheduler;

  localparam int BPM_W   = 32;
  localparam int TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             btn_plus_1, btn_plus_5, btn_minus_1, btn_minus_5;
  logic             uart_msg;
  logic [BPM_W-1:0] uart_bpm_count;
  logic             calc_done;
  logic [BPM_W-1:0] bpm_value;
  logic             bpm_load, bpm_changed, busy, sat, err;

  int   vectors     = 0;
  int   miscompares = 0;
  int   load_cycles;
  logic load_seen;
  logic sat_seen;

  always #5 clk = ~clk;

  bpm_update_scheduler #(
    .BPM_W   (BPM_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_btn_plus_1     (btn_plus_1),
    .i_btn_plus_5     (btn_plus_5),
    .i_btn_minus_1    (btn_minus_1),
    .i_btn_minus_5    (btn_minus_5),
    .i_uart_msg       (uart_msg),
    .i_uart_bpm_count (uart_bpm_count),
    .i_calc_done      (calc_done),
    .o_bpm_value      (bpm_value),
    .o_bpm_load       (bpm_load),
    .o_bpm_changed    (bpm_changed),
    .o_busy           (busy),
    .o_sat            (sat),
    .o_err            (err)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until a load pulse appears or the budget runs out, noting any
  // o_sat pulse on the way.
  task automatic wait_load(input int budget);
    load_seen   = 1'b0;
    sat_seen    = 1'b0;
    load_cycles = 0;
    while (!load_seen && load_cycles < budget) begin
      tick();
      load_cycles++;
      if (sat)      sat_seen  = 1'b1;
      if (bpm_load) load_seen = 1'b1;
    end
  endtask

  task automatic pulse_done();
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
  endtask

  task automatic send_uart(input int value);
    uart_msg       = 1'b1;
    uart_bpm_count = BPM_W'(value);
    tick();
    uart_msg       = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    vectors++; if (bpm_value !== 32'd120) begin miscompares++; $display("[TB] FAIL reset_value: got %0d expected 120", bpm_value); end
    vectors++; if (bpm_load !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load: got %b expected 0", bpm_load); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    reset_n = 1'b1;
    tick();
    vectors++; if (bpm_load !== 1'b1) begin miscompares++; $display("[TB] FAIL init_load: got %b expected 1", bpm_load); end
    vectors++; if (bpm_value !== 32'd120) begin miscompares++; $display("[TB] FAIL init_value: got %0d expected 120", bpm_value); end
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL init_wait_busy: got %b expected 1", busy); end
    pulse_done();
    vectors++; if (bpm_changed !== 1'b1) begin miscompares++; $display("[TB] FAIL init_changed: got %b expected 1", bpm_changed); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL init_idle: got %b expected 0", busy); end
    tick();
    vectors++; if (bpm_changed !== 1'b0) begin miscompares++; $display("[TB] FAIL init_changed_pulse: got %b expected 0", bpm_changed); end
  endtask

  task automatic test_plus5();
    btn_plus_5 = 1'b1;
    tick();
    btn_plus_5 = 1'b0;
    tick();
    tick();
    vectors++; if (bpm_load !== 1'b0) begin miscompares++; $display("[TB] FAIL plus5_early_load: got %b expected 0", bpm_load); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("[TB] FAIL plus5_sat: got %b expected 0", sat); end
    tick();
    vectors++; if (bpm_load !== 1'b1) begin miscompares++; $display("[TB] FAIL plus5_load: got %b expected 1", bpm_load); end
    vectors++; if (bpm_value !== 32'd125) begin miscompares++; $display("[TB] FAIL plus5_value: got %0d expected 125", bpm_value); end
  endtask

  task automatic test_wait_accumulate();
    btn_plus_1 = 1'b1;
    tick(); tick(); tick();
    btn_plus_1  = 1'b0;
    btn_minus_5 = 1'b1;
    tick();
    btn_minus_5 = 1'b0;
    vectors++; if (bpm_value !== 32'd125) begin miscompares++; $display("[TB] FAIL accum_hold: got %0d expected 125", bpm_value); end
    pulse_done();
    vectors++; if (bpm_changed !== 1'b1) begin miscompares++; $display("[TB] FAIL accum_changed: got %b expected 1", bpm_changed); end
    wait_load(10);
    vectors++; if (load_cycles !== 3 || !load_seen) begin miscompares++; $display("[TB] FAIL accum_latency: got %0d cycles expected 3", load_cycles); end
    vectors++; if (bpm_value !== 32'd123) begin miscompares++; $display("[TB] FAIL accum_value: got %0d expected 123", bpm_value); end
    pulse_done();
    wait_load(6);
    vectors++; if (load_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL accum_single_load: got %b expected 0", load_seen); end
  endtask

  task automatic test_clamp();
    send_uart(22);
    wait_load(10);
    vectors++; if (bpm_value !== 32'd22) begin miscompares++; $display("[TB] FAIL clamp_set22: got %0d expected 22", bpm_value); end
    pulse_done();
    btn_minus_5 = 1'b1;
    tick();
    btn_minus_5 = 1'b0;
    wait_load(10);
    vectors++; if (bpm_value !== 32'd20) begin miscompares++; $display("[TB] FAIL clamp_low_value: got %0d expected 20", bpm_value); end
    vectors++; if (sat_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL clamp_low_sat: got %b expected 1", sat_seen); end
    pulse_done();
    send_uart(300);
    wait_load(10);
    vectors++; if (bpm_value !== 32'd300) begin miscompares++; $display("[TB] FAIL clamp_set300: got %0d expected 300", bpm_value); end
    vectors++; if (sat_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL clamp_set300_sat: got %b expected 0", sat_seen); end
    pulse_done();
    send_uart(1000);
    wait_load(8);
    vectors++; if (load_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL clamp_high_noload: got %b expected 0", load_seen); end
    vectors++; if (sat_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL clamp_high_sat: got %b expected 1", sat_seen); end
    vectors++; if (bpm_value !== 32'd300 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL clamp_high_state: got %0d busy %b expected 300 busy 0", bpm_value, busy); end
  endtask

  task automatic test_uart_priority();
    btn_plus_1 = 1'b1;
    send_uart(200);
    btn_plus_1 = 1'b0;
    wait_load(10);
    vectors++; if (bpm_value !== 32'd200) begin miscompares++; $display("[TB] FAIL prio_value: got %0d expected 200", bpm_value); end
    pulse_done();
    wait_load(8);
    vectors++; if (load_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_dropped: got %b expected 0", load_seen); end
    btn_plus_1 = 1'b1;
    tick();
    btn_plus_1 = 1'b0;
    wait_load(10);
    vectors++; if (bpm_value !== 32'd201) begin miscompares++; $display("[TB] FAIL prio_followup: got %0d expected 201", bpm_value); end
    pulse_done();
  endtask

  task automatic test_done_ignored();
    tick();
    pulse_done();
    vectors++; if (bpm_changed !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_done_changed: got %b expected 0", bpm_changed); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_done_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    btn_plus_1 = 1'b1;
    tick();
    btn_plus_1 = 1'b0;
    wait_load(10);
    vectors++; if (bpm_value !== 32'd202) begin miscompares++; $display("[TB] FAIL timeout_load: got %0d expected 202", bpm_value); end
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_early: got err %b busy %b expected err 0 busy 1", err, busy); end
    tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got %b expected 1", err); end
    vectors++; if (busy !== 1'b0 || bpm_changed !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_idle: got busy %b changed %b expected 0 0", busy, bpm_changed); end
    btn_minus_1 = 1'b1;
    tick();
    btn_minus_1 = 1'b0;
    wait_load(10);
    vectors++; if (bpm_value !== 32'd201) begin miscompares++; $display("[TB] FAIL timeout_reload: got %0d expected 201", bpm_value); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky: got %b expected 1", err); end
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_reset_err: got %b expected 0", err); end
    vectors++; if (bpm_value !== 32'd120 || bpm_load !== 1'b0) begin miscompares++; $display("[TB] FAIL wait_reset_value: got %0d load %b expected 120 load 0", bpm_value, bpm_load); end
    reset_n = 1'b1;
    tick();
    vectors++; if (bpm_load !== 1'b1 || bpm_value !== 32'd120) begin miscompares++; $display("[TB] FAIL wait_reset_reload: got load %b value %0d expected 1 120", bpm_load, bpm_value); end
    pulse_done();
    vectors++; if (bpm_changed !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_reset_changed: got %b expected 1", bpm_changed); end
  endtask

  initial begin
    reset_n        = 1'b0;
    btn_plus_1     = 1'b0;
    btn_plus_5     = 1'b0;
    btn_minus_1    = 1'b0;
    btn_minus_5    = 1'b0;
    uart_msg       = 1'b0;
    uart_bpm_count = '0;
    calc_done      = 1'b0;
    $display("[TB] starting bpm_update_scheduler directed tests");
    test_reset();
    test_plus5();
    test_wait_accumulate();
    test_clamp();
    test_uart_priority();
    test_done_ignored();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
